adc_dac_stream_bridge: RTL

Parametrised AXI-Stream sample bridge between an ADC source stream and a DAC sink stream. It generalises the fixed 12-to-14-bit passthrough, adding:
- configurable widths
- MSB-aligned width conversion
- signed offset with saturation
- decimation
- an elastic FIFO with overflow policy

It sits between the pmod ADC and DAC cores at top level.

---
 rtl/adc_dac_stream_bridge_if.sv | 11 +
 rtl/adc_dac_stream_bridge.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/adc_dac_stream_bridge_if.sv
// Valid/ready sample stream bundle used on both sides of adc_dac_stream_bridge.
interface adc_dac_stream_bridge_if #(
  parameter int W = 12
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_dac_stream_bridge.sv
// ADC->DAC stream bridge: MSB-aligned width conversion, saturating offset, decimation, FWFT FIFO.
// Define BRIDGE_STATS_EN to add the drop_count / sample_count statistics outputs.
module adc_dac_stream_bridge #(
  parameter int ADC_W        = 12,
  parameter int DAC_W        = 14,
  parameter int DEPTH        = 16,
  parameter int DROP_ON_FULL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  adc_dac_stream_bridge_if.slave  s_axis,
  adc_dac_stream_bridge_if.master m_axis,
  input  logic                    cfg_enable,
  input  logic [7:0]              cfg_decim,
  input  logic [DAC_W-1:0]        cfg_offset,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow,
  input  logic                    clr_overflow
`ifdef BRIDGE_STATS_EN
  ,
  output logic [15:0]             drop_count,
  output logic [15:0]             sample_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int SW = DAC_W + 2;

  logic [LW-1:0]    count_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [DAC_W-1:0] mem [DEPTH];
  logic             out_valid_reg;
  logic [DAC_W-1:0] out_data_reg;
  logic             pipe_valid_reg;
  logic [DAC_W-1:0] pipe_data_reg;
  logic [7:0]       decim_cnt_reg;
  logic             overflow_reg;

  logic             full_stage;
  logic             accept;
  logic             keep;
  logic             drop;
  logic             load;
  logic             full;
  logic             push;
  logic             pop;
  logic             load_out;
  logic             lost;
  logic [LW-1:0]    mem_count;
  logic [DAC_W-1:0] code;
  logic [DAC_W-1:0] sat;
  logic [SW-1:0]    sum;

  // Occupancy seen by the input: everything already committed downstream, including the pipe stage.
  assign full_stage = ({1'b0, count_reg} + {{LW{1'b0}}, pipe_valid_reg}) >= {1'b0, LW'(DEPTH)};

  generate
    if (DROP_ON_FULL != 0) begin : g_drop
      assign s_axis.tready = !rst;
    end else begin : g_backpressure
      assign s_axis.tready = !rst && (!cfg_enable || !full_stage);
    end
  endgenerate

  assign accept = s_axis.tvalid && s_axis.tready;
  assign keep   = accept && cfg_enable && (decim_cnt_reg == 8'd0);
  assign drop   = keep && full_stage;
  assign load   = keep && !full_stage;

  generate
    if (DAC_W > ADC_W) begin : g_widen
      assign code = {s_axis.tdata, {(DAC_W - ADC_W){1'b0}}};
    end else if (DAC_W == ADC_W) begin : g_same
      assign code = s_axis.tdata;
    end else begin : g_narrow
      assign code = s_axis.tdata[ADC_W-1 -: DAC_W];
    end
  endgenerate

  // Two guard bits: MSB flags a negative sum, the next one flags a sum above full scale.
  assign sum = {2'b00, code} + {{2{cfg_offset[DAC_W-1]}}, cfg_offset};
  assign sat = sum[SW-1] ? '0 : (sum[SW-2] ? '1 : sum[DAC_W-1:0]);

  assign full      = (count_reg == LW'(DEPTH));
  assign push      = pipe_valid_reg && !full;
  assign pop       = out_valid_reg && m_axis.tready;
  assign mem_count = count_reg - LW'(out_valid_reg);
  assign load_out  = (mem_count != '0) && (!out_valid_reg || pop);
  assign lost      = drop || (pipe_valid_reg && full);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= pipe_data_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      pipe_valid_reg <= 1'b0;
      pipe_data_reg  <= '0;
      decim_cnt_reg  <= 8'd0;
      overflow_reg   <= 1'b0;
    end else begin
      pipe_valid_reg <= load;
      if (load) begin
        pipe_data_reg <= sat;
      end

      // A lowered cfg_decim below the current count wraps on the next accept.
      if (!cfg_enable) begin
        decim_cnt_reg <= 8'd0;
      end else if (accept) begin
        decim_cnt_reg <= (decim_cnt_reg >= cfg_decim) ? 8'd0 : decim_cnt_reg + 8'd1;
      end

      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end

      if (load_out) begin
        out_data_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        out_valid_reg <= 1'b1;
      end else if (pop) begin
        out_valid_reg <= 1'b0;
      end

      count_reg <= count_reg + LW'(push) - LW'(pop);

      if (lost) begin
        overflow_reg <= 1'b1;
      end else if (clr_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign m_axis.tvalid = out_valid_reg;
  assign m_axis.tdata  = out_data_reg;
  assign fifo_level    = count_reg;
  assign overflow      = overflow_reg;

`ifdef BRIDGE_STATS_EN
  logic [15:0] drop_count_reg;
  logic [15:0] sample_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_reg   <= 16'd0;
      sample_count_reg <= 16'd0;
    end else begin
      if (clr_overflow) begin
        drop_count_reg <= lost ? 16'd1 : 16'd0;
      end else if (lost && (drop_count_reg != 16'hFFFF)) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
      if (pop) begin
        sample_count_reg <= sample_count_reg + 16'd1;
      end
    end
  end

  assign drop_count   = drop_count_reg;
  assign sample_count = sample_count_reg;
`endif
endmodule
